// File: rtl/spi_reg_if.sv
// Byte-level link between the SPI slave, the register controller and top-level LED logic.
interface spi_reg_if;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [7:0] led;
    logic       busy;
    logic       err;

    modport master (
        output cs_active, rx_valid, rx_data,
        input  tx_data, led, busy, err
    );

    modport slave (
        input  cs_active, rx_valid, rx_data,
        output tx_data, led, busy, err
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: one command byte per frame, then a write or read burst.
// Optional feature macro: SPI_REG_AUTOINC_EN (address advances and wraps after each data byte).
module spi_reg_ctrl #(
    parameter int unsigned NUM_REGS = 8,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input logic       clk,
    input logic       rst_n,
    spi_reg_if.slave  bus
);
    localparam int unsigned   AW      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW-1:0] ID_ADDR = AW'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [7:0]    regs [NUM_REGS];
    logic [7:0]    tx_data;
    logic          err;

    logic          cmd_ok;
    logic [AW-1:0] cmd_idx;
    logic [7:0]    rd_cmd;
    logic [7:0]    rd_cur;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
`ifdef SPI_REG_AUTOINC_EN
        return (a == ID_ADDR) ? '0 : a + AW'(1);
`else
        return a;
`endif
    endfunction

    // Read mux: the top address is the read-only ID register
    always_comb begin
        cmd_ok  = {1'b0, bus.rx_data[6:0]} < 8'(NUM_REGS);
        cmd_idx = AW'(bus.rx_data[6:0]);
        rd_cmd  = (cmd_idx == ID_ADDR) ? ID_VALUE : regs[cmd_idx];
        rd_cur  = (addr == ID_ADDR) ? ID_VALUE : regs[addr];
    end

    // Frame sequencer; a CS release overrides after the current byte is processed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            tx_data <= 8'h00;
            err     <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= 8'h00;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (bus.cs_active) state <= CMD;
                CMD: if (bus.rx_valid) begin
                    if (!cmd_ok) begin
                        state   <= DRAIN;
                        err     <= 1'b1;
                        tx_data <= 8'h00;
                    end else if (bus.rx_data[7]) begin
                        state   <= READ;
                        tx_data <= rd_cmd;
                        addr    <= next_addr(cmd_idx);
                    end else begin
                        state <= WRITE;
                        addr  <= cmd_idx;
                    end
                end
                WRITE: if (bus.rx_valid) begin
                    if (addr != ID_ADDR) regs[addr] <= bus.rx_data;
                    addr <= next_addr(addr);
                end
                READ: if (bus.rx_valid) begin
                    tx_data <= rd_cur;
                    addr    <= next_addr(addr);
                end
                DRAIN:   tx_data <= 8'h00;
                default: state <= IDLE;
            endcase
            if (!bus.cs_active) begin
                state   <= IDLE;
                tx_data <= 8'h00;
            end
        end
    end

    assign bus.tx_data = tx_data;
    assign bus.led     = regs[0];
    assign bus.busy    = (state != IDLE);
    assign bus.err     = err;
endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command/register controller for the SPI slave byte datapath. It consumes received bytes from the SPI slave, decodes a one-byte command (read/write plus register address) and sequences a burst of register writes or reads per chip-select frame. It supplies the next byte to shift out on MISO, and drives the LED register to the top level. It sits between `SPI_Slave` and the top-level LED/status logic, in the 12.09 MHz internal-oscillator clock domain.

## Interface
- `NUM_REGS`, 8: number of 8-bit registers; legal range 2..128.
- `ID_VALUE`, 8'hA5: constant returned by read-only register `NUM_REGS-1`.
- `clk` in 1: system clock (internal oscillator).
- `rst_n` in 1: asynchronous, active-low reset.
- `cs_active` in 1: frame-active level from the SPI slave, already synchronized to `clk`; high while CS is asserted.
- `rx_valid` in 1: single-cycle pulse; `rx_data` holds a complete received byte.
- `rx_data` in 8: received MOSI byte.
- `tx_data` out 8: byte the SPI slave loads for the next MISO byte slot.
- `led` out 8: contents of register 0. The top level inverts it for the pins.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: single-cycle pulse on a protocol error.

## Operation
- Register map:
  - reg 0 = LED.
  - regs 1..`NUM_REGS-2` = scratch R/W.
  - reg `NUM_REGS-1` = read-only, reads `ID_VALUE`; writes to it are ignored silently with no `err`.
- Command byte (first `rx_valid` of a frame):
  - bit7 = 1 read, 0 write.
  - bits6:0 = start address.
- States:
  - IDLE: `cs_active`=1 goes to CMD.
  - CMD:
    - `rx_valid` with addr < `NUM_REGS` goes to READ or WRITE.
    - `rx_valid` with addr ≥ `NUM_REGS` goes to DRAIN and pulses `err`.
  - WRITE: each `rx_valid` sets reg[addr] <= `rx_data`, then addr advances.
  - READ:
    - On entry, `tx_data` <= reg[addr], then addr advances.
    - Each later `rx_valid` (dummy byte, previous MISO byte complete) reloads `tx_data` <= reg[addr], then addr advances.
  - DRAIN: all bytes are ignored and `tx_data` = 8'h00.
- Any state, `cs_active`=0: go to IDLE next cycle. Registers are retained and `tx_data` is forced to 8'h00.
- A frame that ends in CMD with no byte received is a legal no-op, with no `err`.
- Address advance wraps: `NUM_REGS-1` becomes 0.
- `cs_active` falling in the same cycle as `rx_valid`: the byte is fully processed (write committed, or read pointer advanced), then IDLE.
- Reset mid-frame:
  - State returns to IDLE and the in-progress byte is discarded.
  - All R/W registers clear to 0.

## Timing
- Reset values: `tx_data`=8'h00, `led`=8'h00, `busy`=0, `err`=0, state IDLE.
- Write latency: reg (and `led` for reg 0) updates on the clock edge after the `rx_valid` cycle, i.e. visible 1 cycle later.
- Read latency: `tx_data` is valid 1 cycle after the command or dummy `rx_valid`.
- SPI slave constraint: it samples `tx_data` no earlier than 2 `clk` cycles after its `rx_valid` pulse. This holds for SCK ≤ `clk`/4.
- `err`: exactly 1 cycle wide, in the cycle after the offending `rx_valid`.
- `busy`: rises 1 cycle after `cs_active` rises and falls 1 cycle after it falls.
- `rx_valid` pulses are at least 8 cycles apart. Back-to-back pulses are not supported.

## Configuration
- `SPI_REG_AUTOINC_EN` defined: the address advances after every data byte, with wrap as described in Operation.
- `SPI_REG_AUTOINC_EN` undefined:
  - The address stays fixed for the whole frame.
  - Repeated write bytes overwrite the same register; repeated reads return the same register.
  - The wrap logic is not built.

## Test plan
- Reset, then frame: cmd 8'h00, data 8'h3C → `led`=8'h3C one cycle after the data `rx_valid`; `busy` is high for the whole frame and 0 after CS release.
- Write burst: cmd 8'h01, data 8'h11, 8'h22 → reg1=8'h11, reg2=8'h22. Then read frame: cmd 8'h81 → `tx_data`=8'h11 after cmd, 8'h22 after 1st dummy.
- Read of ID with wrap: with `NUM_REGS`=8, cmd 8'h87, 2 dummies → `tx_data` sequence 8'hA5, then reg0. Write 8'hFF to addr 7 → reads back 8'hA5, no `err`.
- Out-of-range: cmd 8'h10 → `err` pulses once, DRAIN; subsequent data bytes modify nothing; `tx_data`=8'h00.
- Boundary: `cs_active` falls in the same cycle as the data `rx_valid` → the write commits, state IDLE next cycle. Reset asserted mid-read → `tx_data`=8'h00 and `led`=8'h00 immediately (asynchronous).
- With `SPI_REG_AUTOINC_EN` undefined: cmd 8'h01, data 8'h55, 8'hAA → reg1=8'hAA, reg2 unchanged at 8'h00.
